// File: rtl/residual_packer.sv
// residual_packer
//
// Takes one header/residual record per 32-pixel RGBA block, derives a
// residual bit width per channel and serialises the block onto a 32-bit
// valid/ready word stream. Block layout: word 0 = minima, word 1 = widths,
// skip flags and raw flag, then either bit-plane words (compressed) or the
// 32 pixels verbatim (raw).
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   hr_reg               header/residual record, sampled only on accept
//   in_valid / in_ready  block handshake (in_ready high only in IDLE)
//   out_data / out_valid / out_ready / out_last  registered word stream

package types;
    typedef struct packed {
        logic [31:0][3:0][7:0] pixels;
    } pixel_block_t;

    typedef struct packed {
        logic [7:0] a_min;
        logic [7:0] b_min;
        logic [7:0] g_min;
        logic [7:0] r_min;
    } min_values_t;

    typedef struct packed {
        min_values_t min_values;
    } header_t;

    typedef struct packed {
        logic [7:0] a_max;
        logic [7:0] b_max;
        logic [7:0] g_max;
        logic [7:0] r_max;
    } max_pixels_t;

    typedef struct packed {
        pixel_block_t pixels;
        header_t      header;
        max_pixels_t  max_pixels;
        logic         compressable;
    } header_residual_reg;
endpackage

module residual_packer (
    input  logic                     clk,
    input  logic                     rst,
    input  types::header_residual_reg hr_reg,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [31:0]              out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last
);

    typedef enum logic [1:0] {IDLE, HDR0, HDR1, PAYLOAD} state_t;

    state_t state_q, state_d;
    logic [1:0] ch_q, ch_d;
    logic [2:0] pl_q, pl_d;
    logic [4:0] idx_q, idx_d;

    logic [31:0][3:0][7:0] pix_q;
    logic [3:0][7:0]       min_q;
    logic [3:0][3:0]       k_q;
    logic                  raw_q;

    logic [3:0][7:0] in_min, in_max;
    logic [3:0][3:0] in_k;
    logic            in_raw;

    logic [31:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        out_last_q, out_last_d;

    logic        accept, advance;
    logic [5:0]  k_sum;
    logic [3:0]  skip;
    logic [2:0]  first_ch, after_q, after_d;
    logic [31:0] plane;

    // Bit length of v: smallest n with v < 2^n.
    function automatic logic [3:0] bit_len(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int b = 0; b < 8; b++)
            if (v[b]) n = 4'(b + 1);
        return n;
    endfunction

    // Lowest channel >= from with a non-zero width; bit 2 set when none.
    function automatic logic [2:0] next_chan(input logic [3:0][3:0] k, input logic [2:0] from);
        logic [2:0] r;
        r = 3'b100;
        for (int c = 3; c >= 0; c--)
            if (3'(c) >= from && k[c] != 4'd0) r = {1'b0, 2'(c)};
        return r;
    endfunction

    assign in_min = hr_reg.header.min_values;
    assign in_max = hr_reg.max_pixels;

    always_comb begin
        for (int c = 0; c < 4; c++)
            in_k[c] = bit_len(in_max[c] - in_min[c]);
        in_raw = !hr_reg.compressable || (in_k == 16'h8888);
    end

    assign accept   = in_valid && (state_q == IDLE);
    assign advance  = out_valid_q && out_ready;
    assign in_ready = (state_q == IDLE);

    assign k_sum = {2'b0, k_q[0]} + {2'b0, k_q[1]} + {2'b0, k_q[2]} + {2'b0, k_q[3]};
    assign skip  = {k_q[3] == 4'd0, k_q[2] == 4'd0, k_q[1] == 4'd0, k_q[0] == 4'd0};

    assign first_ch = next_chan(k_q, 3'd0);
    assign after_q  = next_chan(k_q, {1'b0, ch_q} + 3'd1);
    assign after_d  = next_chan(k_q, {1'b0, ch_d} + 3'd1);

    // Bit-plane word for the channel/plane about to be presented.
    always_comb begin : plane_gen
        logic [7:0] diff;
        diff  = 8'd0;
        plane = 32'd0;
        for (int i = 0; i < 32; i++) begin
            diff     = pix_q[i][ch_d] - min_q[ch_d];
            plane[i] = diff[pl_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ch_q        <= 2'd0;
            pl_q        <= 3'd0;
            idx_q       <= 5'd0;
            out_data_q  <= 32'd0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            pl_q        <= pl_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
        if (accept) begin
            pix_q <= hr_reg.pixels.pixels;
            min_q <= in_min;
            k_q   <= in_k;
            raw_q <= in_raw;
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        pl_d    = pl_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                ch_d  = 2'd0;
                pl_d  = 3'd0;
                idx_d = 5'd0;
                if (in_valid) state_d = HDR0;
            end
            HDR0: if (advance) state_d = HDR1;
            HDR1: if (advance) begin
                if (raw_q) begin
                    state_d = PAYLOAD;
                    idx_d   = 5'd0;
                end else if (k_sum == 6'd0) begin
                    state_d = IDLE;
                end else begin
                    state_d = PAYLOAD;
                    ch_d    = first_ch[1:0];
                    pl_d    = 3'd0;
                end
            end
            PAYLOAD: if (advance) begin
                if (raw_q) begin
                    if (idx_q == 5'd31) state_d = IDLE;
                    else idx_d = idx_q + 5'd1;
                end else if ({1'b0, pl_q} == k_q[ch_q] - 4'd1) begin
                    if (after_q[2]) state_d = IDLE;
                    else begin
                        ch_d = after_q[1:0];
                        pl_d = 3'd0;
                    end
                end else begin
                    pl_d = pl_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are recomputed only when the current word is consumed (or a
    // block is being accepted), so they stay frozen through a stall.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        if (state_q == IDLE || advance) begin
            out_valid_d = (state_d != IDLE);
            out_data_d  = 32'd0;
            out_last_d  = 1'b0;
            case (state_d)
                HDR0: out_data_d = in_min;
                HDR1: begin
                    out_data_d = {raw_q, 11'd0, skip, k_q};
                    out_last_d = !raw_q && (k_sum == 6'd0);
                end
                PAYLOAD: begin
                    if (raw_q) begin
                        out_data_d = pix_q[idx_d];
                        out_last_d = (idx_d == 5'd31);
                    end else begin
                        out_data_d = plane;
                        out_last_d = ({1'b0, pl_d} == k_q[ch_d] - 4'd1) && after_d[2];
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_residual_packer.sv
module tb_residual_packer;

    logic clk = 1'b0;
    logic rst;
    types::header_residual_reg hr_reg;
    types::header_residual_reg next_hr;
    logic in_valid, in_ready;
    logic [31:0] out_data;
    logic out_valid, out_ready, out_last;

    always #5 clk = ~clk;

    residual_packer dut (
        .clk       (clk),
        .rst       (rst),
        .hr_reg    (hr_reg),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    int total = 0;
    int fails = 0;

    logic [7:0] px [32][4];
    logic       comp;
    logic [31:0] exp_w [$];
    logic        exp_l [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic set_const(input logic [31:0] v);
        for (int i = 0; i < 32; i++)
            for (int c = 0; c < 4; c++) px[i][c] = v[8*c +: 8];
        comp = 1'b1;
    endtask

    task automatic set_ramp();
        for (int i = 0; i < 32; i++) begin
            px[i][0] = 8'(i);
            px[i][1] = 8'd0;
            px[i][2] = 8'd0;
            px[i][3] = 8'd0;
        end
        comp = 1'b1;
    endtask

    task automatic set_full();
        for (int i = 0; i < 32; i++)
            for (int c = 0; c < 4; c++) px[i][c] = 8'($urandom_range(0, 255));
        for (int c = 0; c < 4; c++) begin
            px[0][c] = 8'd0;
            px[1][c] = 8'd255;
        end
        comp = 1'b1;
    endtask

    task automatic set_random();
        int base, span;
        for (int c = 0; c < 4; c++) begin
            base = int'($urandom_range(0, 255));
            span = (1 << $urandom_range(0, 8)) - 1;
            for (int i = 0; i < 32; i++)
                px[i][c] = 8'(base + int'($urandom_range(0, span)));
        end
        comp = ($urandom_range(0, 9) != 0);
    endtask

    // Header stage stand-in: real minima/maxima of the current block.
    function automatic types::header_residual_reg make_hr();
        types::header_residual_reg h;
        logic [7:0] mn [4];
        logic [7:0] mx [4];
        h = '0;
        for (int c = 0; c < 4; c++) begin
            mn[c] = 8'd255;
            mx[c] = 8'd0;
            for (int i = 0; i < 32; i++) begin
                if (px[i][c] < mn[c]) mn[c] = px[i][c];
                if (px[i][c] > mx[c]) mx[c] = px[i][c];
                h.pixels.pixels[i][c] = px[i][c];
            end
        end
        h.header.min_values.r_min = mn[0];
        h.header.min_values.g_min = mn[1];
        h.header.min_values.b_min = mn[2];
        h.header.min_values.a_min = mn[3];
        h.max_pixels.r_max = mx[0];
        h.max_pixels.g_max = mx[1];
        h.max_pixels.b_max = mx[2];
        h.max_pixels.a_max = mx[3];
        h.compressable = comp;
        return h;
    endfunction

    // Expected word stream straight from the block-format rules.
    task automatic build_model();
        int mn [4];
        int mx [4];
        int k [4];
        int r;
        bit raw;
        logic [31:0] w;
        exp_w.delete();
        exp_l.delete();
        for (int c = 0; c < 4; c++) begin
            mn[c] = 255;
            mx[c] = 0;
            for (int i = 0; i < 32; i++) begin
                if (int'(px[i][c]) < mn[c]) mn[c] = int'(px[i][c]);
                if (int'(px[i][c]) > mx[c]) mx[c] = int'(px[i][c]);
            end
            k[c] = 0;
            while (k[c] < 8 && (mx[c] - mn[c]) >= (1 << k[c])) k[c]++;
        end
        raw = !comp || (k[0] == 8 && k[1] == 8 && k[2] == 8 && k[3] == 8);
        exp_w.push_back({8'(mn[3]), 8'(mn[2]), 8'(mn[1]), 8'(mn[0])});
        w = 32'd0;
        for (int c = 0; c < 4; c++) begin
            w[4*c +: 4] = 4'(k[c]);
            w[16 + c]   = (k[c] == 0);
        end
        w[31] = raw;
        exp_w.push_back(w);
        if (raw) begin
            for (int i = 0; i < 32; i++)
                exp_w.push_back({px[i][3], px[i][2], px[i][1], px[i][0]});
        end else begin
            for (int c = 0; c < 4; c++)
                for (int p = 0; p < k[c]; p++) begin
                    w = 32'd0;
                    for (int i = 0; i < 32; i++) begin
                        r = int'(px[i][c]) - mn[c];
                        w[i] = ((r >> p) & 1) != 0;
                    end
                    exp_w.push_back(w);
                end
        end
        for (int n = 0; n < exp_w.size(); n++) exp_l.push_back(n == exp_w.size() - 1);
    endtask

    // Called at a negedge with hr_reg already applied. Sends the block,
    // collects its words with out_ready high ready_pct % of the time.
    task automatic run_block(input string tag, input int ready_pct, input bit hold_valid);
        int n, cyc, nexp;
        bit done, stalled, r;
        logic [31:0] pd;
        logic pl;
        n = 0;
        done = 0;
        stalled = 0;
        pd = 32'd0;
        pl = 1'b0;
        nexp = exp_w.size();
        in_valid = 1'b1;
        cyc = 0;
        while (!in_ready && cyc < 100) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        check({tag, " accept"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        if (hold_valid) hr_reg = next_hr;
        else in_valid = 1'b0;
        check({tag, " latency"}, 32'(out_valid), 32'd1);
        cyc = 0;
        while (!done && cyc < 500) begin
            r = ($urandom_range(0, 99) < ready_pct);
            if (out_valid !== 1'b1) begin
                check({tag, " valid_drop"}, 32'(out_valid), 32'd1);
                done = 1;
            end else begin
                check({tag, " busy_in_ready"}, 32'(in_ready), 32'd0);
                if (stalled) begin
                    check({tag, " stall_data"}, out_data, pd);
                    check({tag, " stall_last"}, 32'(out_last), 32'(pl));
                end
                if (r) begin
                    check($sformatf("%s word%0d", tag, n), out_data, exp_w[n]);
                    check($sformatf("%s last%0d", tag, n), 32'(out_last), 32'(exp_l[n]));
                    if (n == nexp - 1) done = 1;
                    n++;
                end
                stalled = !r;
                pd = out_data;
                pl = out_last;
                out_ready = r;
                @(posedge clk);
                @(negedge clk);
            end
            cyc++;
        end
        check({tag, " word_count"}, 32'(n), 32'(nexp));
        check({tag, " back_idle"}, {29'd0, in_ready, out_valid, out_last}, 32'b100);
    endtask

    task automatic lit_const();
        exp_w = '{32'h11223344, 32'h000F0000};
        exp_l = '{1'b0, 1'b1};
    endtask

    task automatic lit_ramp();
        exp_w = '{32'h00000000, 32'h000E0005, 32'hAAAAAAAA, 32'hCCCCCCCC,
                  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFFF0000};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        hr_reg = '0;
        next_hr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_last", 32'(out_last), 32'd0);
        check("reset_out_data", out_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        set_const(32'h11223344);
        hr_reg = make_hr();
        lit_const();
        run_block("const", 100, 0);

        set_ramp();
        hr_reg = make_hr();
        lit_ramp();
        run_block("ramp", 100, 0);

        set_full();
        hr_reg = make_hr();
        build_model();
        run_block("full", 100, 0);

        set_const(32'h11223344);
        comp = 1'b0;
        hr_reg = make_hr();
        build_model();
        run_block("forced_raw", 100, 0);

        for (int t = 0; t < 8; t++) begin
            set_random();
            hr_reg = make_hr();
            build_model();
            run_block($sformatf("rand%0d", t), int'($urandom_range(30, 100)), 0);
        end

        // Backpressure: ramp under random ready; in_valid stays high with a
        // second block presented as soon as the ramp is accepted.
        set_random();
        next_hr = make_hr();
        set_ramp();
        hr_reg = make_hr();
        lit_ramp();
        run_block("bp_ramp", 50, 1);
        hr_reg = next_hr;
        for (int i = 0; i < 32; i++)
            for (int c = 0; c < 4; c++) px[i][c] = next_hr.pixels.pixels[i][c];
        comp = next_hr.compressable;
        build_model();
        run_block("bp_next", 50, 0);

        // Reset in the middle of the ramp payload.
        set_ramp();
        hr_reg = make_hr();
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("midrst_before_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_last", 32'(out_last), 32'd0);
        rst = 1'b0;
        set_const(32'h11223344);
        hr_reg = make_hr();
        lit_const();
        run_block("post_rst", 100, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
